// File: rtl/regfile_sb_pkg.sv
// Shared types for the scoreboarded register file: default geometry, address/tag/data
// types and the writeback-port bundle used by the top-level datapath.
package regfile_sb_pkg;

    localparam int SB_XLEN = 64;
    localparam int SB_NREG = 32;
    localparam int SB_AW   = $clog2(SB_NREG);
    localparam int SB_TAGW = 4;

    typedef logic [SB_AW-1:0]   reg_addr_t;
    typedef logic [SB_TAGW-1:0] tag_t;
    typedef logic [SB_XLEN-1:0] data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        tag_t      tag;
        data_t     data;
    } wb_port_t;

    // True when the address names the hardwired zero register.
    function automatic logic is_hardwired_zero(input logic zero_en, input reg_addr_t addr);
        return zero_en && (addr == '0);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-producer scoreboard: per-register busy/tag state, writeback acceptance
// against the outstanding tag, issue/flush priority and the saturating stale-drop count.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG     = SB_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NWR      = 2,
    parameter int TAGW     = SB_TAGW,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NWR-1:0]       wvalid,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*TAGW-1:0]  wtag,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic                 flush,
    output logic [NWR-1:0]       w_accept,
    output logic [NREG-1:0]      busy,
    output logic [CNTW-1:0]      stale_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [TAGW-1:0] tag_q [NREG];
    logic [TAGW-1:0] tag_d [NREG];
    logic [CNTW-1:0] stale_cnt_q, stale_cnt_d;
    logic [CNTW:0]   stale_sum;

    logic [AW-1:0]   wa_p   [NWR];
    logic [TAGW-1:0] wtag_p [NWR];
    logic [NWR-1:0]  zero_p;
    logic [NWR-1:0]  stale_p;
    logic [NWR-1:0]  wr_hit [NREG];
    logic            iss_ok;

    genvar gi, gr;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_port
            assign wa_p[gi]     = wa[gi*AW +: AW];
            assign wtag_p[gi]   = wtag[gi*TAGW +: TAGW];
            assign zero_p[gi]   = is_hardwired_zero(ZERO_REG != 0, reg_addr_t'(wa_p[gi]));
            // A write lands if nobody is pending, or it comes from the pending producer.
            assign w_accept[gi] = wvalid[gi] && !zero_p[gi] &&
                                  (!busy_q[wa_p[gi]] || (tag_q[wa_p[gi]] == wtag_p[gi]));
            assign stale_p[gi]  = wvalid[gi] && !zero_p[gi] && !w_accept[gi];
            for (gr = 0; gr < NREG; gr++) begin : g_hit
                assign wr_hit[gr][gi] = w_accept[gi] && (wa_p[gi] == AW'(gr));
            end
        end
    endgenerate

    assign iss_ok = iss_valid && !is_hardwired_zero(ZERO_REG != 0, reg_addr_t'(iss_rd));

    // Priority per register: flush, then a new issue, then a clearing writeback.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_ok && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = iss_tag;
            end else if (|wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // The extra carry bit catches overflow so the count pins at all-ones.
    always_comb begin
        stale_sum = {1'b0, stale_cnt_q};
        for (int p = 0; p < NWR; p++) begin
            stale_sum = stale_sum + {{CNTW{1'b0}}, stale_p[p]};
        end
        stale_cnt_d = stale_sum[CNTW] ? {CNTW{1'b1}} : stale_sum[CNTW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q      <= '0;
            tag_q       <= '{default: '0};
            stale_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign stale_cnt = stale_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, optional zero register and an
// embedded tag scoreboard that filters stale writebacks and drives per-port busy.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN     = SB_XLEN,
    parameter int NREG     = SB_NREG,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int TAGW     = SB_TAGW,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 16,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wvalid,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*TAGW-1:0]  wtag,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic                 flush,
    output logic [CNTW-1:0]      stale_cnt
);

    wb_port_t           wb [NWR];
    logic [NWR-1:0]     sb_wvalid;
    logic [NWR*AW-1:0]  sb_wa;
    logic [NWR*TAGW-1:0] sb_wtag;
    logic [NWR-1:0]     w_accept;
    logic [NREG-1:0]    busy;

    logic [XLEN-1:0]    regs_q [NREG];
    logic [XLEN-1:0]    regs_d [NREG];
    logic [AW-1:0]      ra_p   [NRD];
    logic [XLEN-1:0]    rd_p   [NRD];

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wb
            assign wb[gi] = '{valid: wvalid[gi],
                              addr:  reg_addr_t'(wa[gi*AW +: AW]),
                              tag:   tag_t'(wtag[gi*TAGW +: TAGW]),
                              data:  data_t'(wd[gi*XLEN +: XLEN])};
            assign sb_wvalid[gi]            = wb[gi].valid;
            assign sb_wa[gi*AW +: AW]       = AW'(wb[gi].addr);
            assign sb_wtag[gi*TAGW +: TAGW] = TAGW'(wb[gi].tag);
        end
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            assign ra_p[gi]              = ra[gi*AW +: AW];
            assign rd[gi*XLEN +: XLEN]   = rd_p[gi];
        end
    endgenerate

    regfile_sb_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NWR      (NWR),
        .TAGW     (TAGW),
        .ZERO_REG (ZERO_REG),
        .CNTW     (CNTW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wvalid    (sb_wvalid),
        .wa        (sb_wa),
        .wtag      (sb_wtag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .flush     (flush),
        .w_accept  (w_accept),
        .busy      (busy),
        .stale_cnt (stale_cnt)
    );

    // Ascending port order lets the highest-index accepted write win.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++) begin
            if (w_accept[p]) begin
                regs_d[AW'(wb[p].addr)] = XLEN'(wb[p].data);
            end
        end
    end

    // Reads see this cycle's accepted writes; a landing write also retires busy.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_p[i]    = regs_q[ra_p[i]];
            rd_busy[i] = busy[ra_p[i]];
            for (int p = 0; p < NWR; p++) begin
                if (w_accept[p] && (AW'(wb[p].addr) == ra_p[i])) begin
                    rd_p[i]    = XLEN'(wb[p].data);
                    rd_busy[i] = 1'b0;
                end
            end
            if (is_hardwired_zero(ZERO_REG != 0, reg_addr_t'(ra_p[i]))) begin
                rd_p[i]    = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based architectural model.
module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int TAGW = 4;
    localparam int CNTW = 16;
    localparam int SMAX = 65535;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wvalid;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*TAGW-1:0]  wtag;
    logic [NWR*XLEN-1:0]  wd;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [TAGW-1:0]      iss_tag;
    logic                 flush;
    logic [CNTW-1:0]      stale_cnt;

    // Stimulus variables
    logic [AW-1:0]   ra_a   [NRD];
    logic            wv_a   [NWR];
    logic [AW-1:0]   wa_a   [NWR];
    logic [TAGW-1:0] wtag_a [NWR];
    logic [XLEN-1:0] wd_a   [NWR];

    // Architectural model
    logic [XLEN-1:0] m_reg  [NREG];
    logic            m_busy [NREG];
    logic [TAGW-1:0] m_tag  [NREG];
    int              m_stale;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = ra_a[i];
        for (int p = 0; p < NWR; p++) begin
            wvalid[p]              = wv_a[p];
            wa[p*AW +: AW]         = wa_a[p];
            wtag[p*TAGW +: TAGW]   = wtag_a[p];
            wd[p*XLEN +: XLEN]     = wd_a[p];
        end
    end

    regfile_sb dut (
        .clk       (clk),
        .reset     (reset),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .wvalid    (wvalid),
        .wa        (wa),
        .wtag      (wtag),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .flush     (flush),
        .stale_cnt (stale_cnt)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
        m_stale = 0;
    endtask

    function automatic bit model_acc(input int p);
        return wv_a[p] && (wa_a[p] != 0) && (!m_busy[wa_a[p]] || (m_tag[wa_a[p]] == wtag_a[p]));
    endfunction

    task automatic idle();
        for (int p = 0; p < NWR; p++) begin
            wv_a[p] = 1'b0; wa_a[p] = '0; wtag_a[p] = '0; wd_a[p] = '0;
        end
        iss_valid = 1'b0; iss_rd = '0; iss_tag = '0; flush = 1'b0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
        ra_a[0] = AW'(a0); ra_a[1] = AW'(a1); ra_a[2] = AW'(a2); ra_a[3] = AW'(a3);
    endtask

    // Called just after a falling edge with inputs applied: check, then advance the model.
    task automatic cycle(input string name);
        bit acc [NWR];
        int nstale;
        bit hit;
        logic [XLEN-1:0] exp_d;
        logic exp_b;
        #1;
        for (int i = 0; i < NRD; i++) begin
            exp_d = m_reg[ra_a[i]];
            exp_b = m_busy[ra_a[i]];
            for (int p = 0; p < NWR; p++) begin
                if (model_acc(p) && wa_a[p] == ra_a[i]) begin
                    exp_d = wd_a[p];
                    exp_b = 1'b0;
                end
            end
            if (ra_a[i] == 0) begin
                exp_d = '0;
                exp_b = 1'b0;
            end
            check_eq($sformatf("%s rd%0d(x%0d)", name, i, ra_a[i]), rd[i*XLEN +: XLEN], exp_d);
            check_eq($sformatf("%s busy%0d(x%0d)", name, i, ra_a[i]), XLEN'(rd_busy[i]), XLEN'(exp_b));
        end
        check_eq($sformatf("%s stale_cnt", name), XLEN'(stale_cnt), XLEN'(m_stale));
        @(posedge clk);
        nstale = 0;
        for (int p = 0; p < NWR; p++) begin
            acc[p] = model_acc(p);
            if (wv_a[p] && wa_a[p] != 0 && !acc[p]) nstale++;
        end
        for (int p = 0; p < NWR; p++) if (acc[p]) m_reg[wa_a[p]] = wd_a[p];
        for (int r = 1; r < NREG; r++) begin
            hit = 1'b0;
            for (int p = 0; p < NWR; p++) if (acc[p] && wa_a[p] == r) hit = 1'b1;
            if (flush) m_busy[r] = 1'b0;
            else if (iss_valid && iss_rd == r) begin
                m_busy[r] = 1'b1;
                m_tag[r]  = iss_tag;
            end else if (hit) m_busy[r] = 1'b0;
        end
        m_stale = (m_stale + nstale > SMAX) ? SMAX : m_stale + nstale;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        set_ra(0, 1, 5, 31);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        cycle("reset");

        idle(); set_ra(5, 1, 5, 31);
        wv_a[0] = 1'b1; wa_a[0] = 5; wd_a[0] = 64'hDEAD_BEEF;
        cycle("raw_bypass");
        idle(); cycle("raw_hold");

        idle(); set_ra(7, 0, 5, 7);
        wv_a[0] = 1'b1; wa_a[0] = 7; wd_a[0] = 64'h11;
        wv_a[1] = 1'b1; wa_a[1] = 7; wd_a[1] = 64'h22;
        cycle("dual_wr");
        idle(); cycle("dual_wr_hold");

        idle(); set_ra(0, 7, 5, 0);
        wv_a[0] = 1'b1; wa_a[0] = 0; wd_a[0] = 64'hFF;
        cycle("x0_wr");
        idle(); cycle("x0_hold");

        idle(); set_ra(3, 3, 0, 5);
        iss_valid = 1'b1; iss_rd = 3; iss_tag = 2;
        cycle("iss_x3");
        idle(); wv_a[0] = 1'b1; wa_a[0] = 3; wtag_a[0] = 1; wd_a[0] = 64'h55;
        cycle("stale_x3");
        idle(); wv_a[1] = 1'b1; wa_a[1] = 3; wtag_a[1] = 2; wd_a[1] = 64'h66;
        cycle("match_x3");
        idle(); cycle("x3_hold");

        idle(); set_ra(4, 4, 3, 7);
        iss_valid = 1'b1; iss_rd = 4; iss_tag = 0;
        cycle("iss_x4_t0");
        idle(); iss_valid = 1'b1; iss_rd = 4; iss_tag = 3;
        wv_a[0] = 1'b1; wa_a[0] = 4; wtag_a[0] = 0; wd_a[0] = 64'h9;
        cycle("iss_vs_wb");
        idle(); cycle("x4_busy");
        idle(); wv_a[0] = 1'b1; wa_a[0] = 4; wtag_a[0] = 3; wd_a[0] = 64'hA;
        cycle("x4_t3_wb");

        idle(); set_ra(8, 9, 4, 3);
        iss_valid = 1'b1; iss_rd = 8; iss_tag = 1;
        cycle("iss_x8");
        idle(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 9; iss_tag = 5;
        cycle("flush_iss");
        idle(); cycle("post_flush");

        for (int n = 0; n < 1500; n++) begin
            idle();
            for (int i = 0; i < NRD; i++)
                ra_a[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 15));
            for (int p = 0; p < NWR; p++) begin
                wv_a[p]   = $urandom_range(0, 1) == 1;
                wa_a[p]   = AW'($urandom_range(0, 15));
                wtag_a[p] = TAGW'($urandom_range(0, 3));
                wd_a[p]   = {$urandom, $urandom};
            end
            iss_valid = $urandom_range(0, 2) == 0;
            iss_rd    = AW'($urandom_range(0, 15));
            iss_tag   = TAGW'($urandom_range(0, 3));
            flush     = $urandom_range(0, 19) == 0;
            cycle($sformatf("rand%0d", n));
        end

        idle(); set_ra(3, 4, 7, 9);
        cycle("pre_reset");
        reset = 1'b0;
        #1;
        check_eq("async_reset rd0", rd[0 +: XLEN], '0);
        check_eq("async_reset rd1", rd[XLEN +: XLEN], '0);
        check_eq("async_reset stale_cnt", XLEN'(stale_cnt), '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle("after_reset");

        idle(); set_ra(10, 0, 1, 10);
        iss_valid = 1'b1; iss_rd = 10; iss_tag = 5;
        cycle("iss_x10");
        idle();
        for (int p = 0; p < NWR; p++) begin
            wv_a[p] = 1'b1; wa_a[p] = 10; wtag_a[p] = 6; wd_a[p] = 64'hBAD;
        end
        for (int n = 0; n < ((1 << CNTW) + 3 + NWR - 1) / NWR; n++) cycle("sat");
        cycle("sat_end");
        check_eq("sat stale_cnt max", XLEN'(stale_cnt), XLEN'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a built-in tagged scoreboard; next-generation replacement for the single-write/dual-read file in the decode/writeback path.
- Supports NRD read ports and NWR writeback ports, same-cycle write-to-read bypass, and optional hardwired zero register.
- Tracks per-register pending-producer state with a tag, drops stale writebacks, and supports a pipeline flush.
- Sits between decode (reads, issue) and writeback (commits); the issue logic stalls on the per-port busy outputs.

Parameters:
XLEN, 64, data width in bits
NREG, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREG)
NRD, 4, read ports
NWR, 2, writeback ports
TAGW, 4, producer tag width
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
CNTW, 16, stale-drop counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ra  in  NRD×AW  read addresses
rd  out  NRD×XLEN  read data, bypassed
rd_busy  out  NRD  register has an outstanding producer after this cycle's writebacks
wvalid  in  NWR  writeback valid per port
wa  in  NWR×AW  writeback address
wtag  in  NWR×TAGW  writeback producer tag
wd  in  NWR×XLEN  writeback data
iss_valid  in  1  new producer issued for iss_rd
iss_rd  in  AW  destination register of issued instruction
iss_tag  in  TAGW  tag of issued producer
flush  in  1  clear all busy state (synchronous)
stale_cnt  out  CNTW  saturating count of dropped stale writebacks

Behaviour:
- Reset (reset=0, async): all registers 0, all busy 0, all tags 0, stale_cnt 0. Therefore rd = 0 and rd_busy = 0.
- Write acceptance per port p: accept if wvalid[p] && !(ZERO_REG && wa==0) && (!busy_q[wa] || tag_q[wa]==wtag[p]).
  - Not accepted with wvalid=1 and nonzero address → stale drop.
- Same address on several accepted ports in one cycle: highest port index wins for data. All matching-tag ports clear busy.
- Data commit: accepted write updates the register at the next rising edge.
- Read (combinational): rd[i] = 0 if ZERO_REG && ra[i]==0. Else the winning accepted write data to ra[i] this cycle, if any. Else the stored value.
  - Zero-cycle read-after-write bypass is required.
- Busy next-state per register r, in priority order:
  - flush → 0.
  - iss_valid && iss_rd==r (and r≠0 when ZERO_REG) → busy=1, tag=iss_tag.
  - Accepted write to r → busy=0.
  - Otherwise hold.
- Issue beats same-cycle writeback to the same register. The write data still commits (old producer, tag matched the old tag); busy stays set for the new producer.
- Flush beats issue in the same cycle. Register data is unaffected by flush; same-cycle writebacks still commit under normal acceptance rules.
- rd_busy[i] = busy_q[ra[i]] && no accepted write to ra[i] this cycle. Issue does not affect rd_busy until the next cycle. rd_busy = 0 for ZERO_REG register 0.
- stale_cnt: increments by the number of stale drops this cycle (0..NWR), saturating at 2^CNTW−1, never wraps. Cleared only by reset.
- Reset mid-operation: asynchronous and immediate; all pending issues and writebacks are lost.
- Latency: writes and issue take effect 1 cycle after the edge; reads and bypass take 0 cycles.

Decomposition:
- Shared package: XLEN and default NREG; reg-address, tag and data typedefs; a writeback-port struct {valid, addr, tag, data} used as the array element for wvalid/wa/wtag/wd.
- Sub-module regfile_sb_scoreboard: holds busy/tag arrays, issue/flush/clear priority and the acceptance mask. It outputs per-port accept and per-register busy to the data array in the top module.

Test Plan:
- Reset then read all ports at addresses 0,1,5,31 → rd all 0, rd_busy all 0, stale_cnt 0.
- Write x5=0xDEAD_BEEF on port0 while reading ra0=5 same cycle → rd0=0xDEAD_BEEF same cycle and on the following cycle.
- Port0 and port1 both write x7 (0x11, 0x22), not busy → x7=0x22. Write to x0=0xFF → x0 reads 0, stale_cnt unchanged.
- Issue x3 tag 2, then writeback x3 tag 1 val 0x55 → dropped: x3 unchanged, rd_busy=1, stale_cnt=1. Then writeback tag 2 val 0x66 → x3=0x66 bypassed, rd_busy=0 same cycle.
- Same cycle: issue x4 tag 3 and writeback x4 old tag 0 val 0x9 (x4 busy tag 0) → x4=0x9, next cycle busy=1 with tag 3.
- Issue x8, then flush with simultaneous issue x9 → both not busy. Saturation run: force 2^CNTW+3 stale drops → stale_cnt stays at 0xFFFF.
